axi_tensor_wb: RTL and testbench
================================

# axi_tensor_wb

Parametrised write-back engine that streams the PE-array accumulator regfiles to DRAM over an AXI4 write channel. It generalises the single-burst 32-bit writer: configurable array size, accumulator width and beat width, a runtime base address, and automatic splitting into bursts that never exceed `MAX_BURST` or cross a 4 KB boundary. It also handles the B-channel response with error reporting. It sits between the PE array and the AXI interconnect and is started by the tensor controller once the computation is complete.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 64: beat width; multiple of 32, ≤ 256.
- `ROWS`, 8: PE rows.
- `COLS`, 8: PE columns.
- `ACC_WIDTH`, 128: bits per PE regfile entry; multiple of 64.
- `MAX_BURST`, 16: max beats per burst; power of 2, ≤ 256.
- Reset: rst is asynchronous and active-high; clock is clk.
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: byte address; DATA_WIDTH/8 aligned; sampled with start.
- `pack16` in 1: FP16 non-mixed packing; sampled with start.
- `regfiles` in ROWS*COLS*ACC_WIDTH: `[r][c]` entry; must be held stable while busy.
- `busy` out 1: high from the cycle after start until done.
- `done` out 1: one-cycle pulse after the final B handshake.
- `err` out 1: sticky for the job, set on any bresp≠OKAY; cleared by start.
- `axi_awvalid`/`axi_awready`: out/in 1.
- `axi_awaddr` out ADDR_WIDTH.
- `axi_awlen` out 8.
- `axi_awsize` out 3: constant log2(DATA_WIDTH/8).
- `axi_awburst` out 2: constant INCR (01).
- `axi_wvalid`/`axi_wready`: out/in 1.
- `axi_wdata` out DATA_WIDTH.
- `axi_wstrb` out DATA_WIDTH/8: all ones.
- `axi_wlast` out 1.
- `axi_bvalid`/`axi_bready`/`axi_bresp`: in/out/in 1/1/2.

## Operation
- **Word stream:** 32-bit words in wave-major order, index = wave*ROWS*COLS + r*COLS + c.
  - Normal mode: the word is `rf[wave*32 +: 32]`, with waves = ACC_WIDTH/32.
  - pack16 mode: the word is `{rf[(2w+1)*32 +: 16], rf[2w*32 +: 16]}`, with waves = ACC_WIDTH/64.
- **Beats:** a beat packs L = DATA_WIDTH/32 consecutive words, with the lowest index in bits [31:0]. Total beats T = ROWS*COLS*waves/L.
- **Burst length:** len = min(MAX_BURST, beats remaining, beats to the next 4 KB boundary of the current address). `awaddr` = base + beats_sent*DATA_WIDTH/8. `awlen` = len−1.
- **FSM:**
  - IDLE → ADDR on start. Latch base and pack16, clear counters and err.
  - ADDR: awvalid=1 → DATA on aw handshake.
  - DATA: wvalid=1. Each w handshake advances the word index by L. wlast=1 on the last beat of the burst; that handshake → RESP.
  - RESP: bready=1. The b handshake ORs (bresp≠00) into err, then goes → ADDR if beats remain, else → IDLE with done=1.
- Exactly one burst is outstanding at a time.
- start while busy is ignored.
- Reset mid-job: FSM returns to IDLE immediately, all valids/bready/done/busy/err low, and the job is abandoned. The interconnect must be reset with it.

## Timing
- Reset values: every output is 0 except the constants `awsize` and `awburst`; `wstrb` is all ones.
- `awvalid` rises the cycle after start.
- `wvalid` rises the cycle after the aw handshake.
- `bready` rises the cycle after the wlast handshake.
- `wdata` and `wlast` are functions of registered counters only. They are stable while wvalid && !wready.
- awvalid/wvalid never drop without a handshake.
- Zero-wait slave throughput: one beat per cycle in DATA. Per-burst overhead is 2 cycles (ADDR + RESP).
- done is asserted the cycle after the final b handshake, with busy falling in the same cycle.
- A start in the same cycle as done is ignored. start is accepted the next cycle.

## Structure
- Shared package `params`:
  - `AXI_BURST_INCR`
  - `AXI_RESP_OKAY`
  - function `clog2_bytes`
  - the wave-major index constants
- Sub-module `tensor_word_sel`: combinational. Inputs are regfiles, word index, and pack16; output is an L-word beat. It is instantiated once.
- The top holds the FSM, beat/burst counters, 4 KB distance computation, and err.

## Test plan
- **Defaults, normal mode:** base=0x0, zero-wait slave → 8 bursts, awaddr 0x0, 0x80, … 0x380, awlen=15. 128 beats. First beat = `{rf[0][1][31:0], rf[0][0][31:0]}`. done once.
- **pack16=1:** 64 beats in 4 bursts. Beat 0 lane 0 = `{rf[0][0][47:32], rf[0][0][15:0]}`. Word 64 = `{rf[0][0][111:96], rf[0][0][79:64]}`.
- **4 KB split:** base=0xFC0 → first burst awaddr 0xFC0, awlen=7. Second burst awaddr 0x1000, awlen=15. The last burst is shortened to 8 beats, for a total of 128 beats.
- **Backpressure:** random awready/wready/bvalid gaps → wdata and wlast are stable during stalls, and no beat is lost or duplicated (scoreboard).
- **Error response:** bresp=SLVERR (10) on burst 3 → all bursts still issue, err=1 at done. A new start clears err.
- **Reset mid-DATA:** rst asserted at beat 40 → all outputs are 0 the same cycle. A subsequent start runs the full job cleanly.

Source files
------------

// File: rtl/axi_tensor_wb_pkg.sv
// rtl/axi_tensor_wb_pkg.sv - shared AXI constants, FSM state type and word-order helpers
package axi_tensor_wb_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int          WORD_BITS      = 32;
  localparam int          HALF_BITS      = 16;
  localparam logic [12:0] BOUNDARY_BYTES = 13'd4096;
  localparam int          BOUNDARY_LSB   = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } wb_state_e;

  function automatic logic [2:0] clog2_bytes(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  // Wave-major order: word index = wave * (ROWS*COLS) + pe, with pe = r*COLS + c.
  function automatic int wave_of(input int idx, input int npe);
    return idx / npe;
  endfunction

  function automatic int pe_of(input int idx, input int npe);
    return idx % npe;
  endfunction

endpackage

// File: rtl/tensor_word_sel.sv
// rtl/tensor_word_sel.sv - selects the LANES consecutive 32-bit words of one write beat
module tensor_word_sel
  import axi_tensor_wb_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int ACC_WIDTH = 128,
  parameter int LANES     = 2,
  parameter int IDX_W     = 9
) (
  input  logic [ROWS*COLS*ACC_WIDTH-1:0] regfiles_i,
  input  logic [IDX_W-1:0]               word_idx_i,
  input  logic                           pack16_i,
  output logic [LANES*WORD_BITS-1:0]     beat_o
);

  localparam int NPE = ROWS * COLS;

  logic [ACC_WIDTH-1:0] entry;
  int                   wave;
  int                   pe;

  always_comb begin
    beat_o = '0;
    entry  = '0;
    wave   = 0;
    pe     = 0;
    for (int k = 0; k < LANES; k++) begin
      wave  = wave_of(int'(word_idx_i) + k, NPE);
      pe    = pe_of(int'(word_idx_i) + k, NPE);
      entry = regfiles_i[pe*ACC_WIDTH +: ACC_WIDTH];
      // pack16 keeps the low FP16 half of two adjacent 32-bit accumulator slots
      if (pack16_i)
        beat_o[k*WORD_BITS +: WORD_BITS] = {entry[(2*wave+1)*WORD_BITS +: HALF_BITS],
                                            entry[2*wave*WORD_BITS +: HALF_BITS]};
      else
        beat_o[k*WORD_BITS +: WORD_BITS] = entry[wave*WORD_BITS +: WORD_BITS];
    end
  end

endmodule

// File: rtl/axi_tensor_wb.sv
// rtl/axi_tensor_wb.sv - streams PE-array accumulators to DRAM as 4KB-safe AXI4 write bursts
module axi_tensor_wb
  import axi_tensor_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ACC_WIDTH  = 128,
  parameter int MAX_BURST  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic                           pack16,
  input  logic [ROWS*COLS*ACC_WIDTH-1:0] regfiles,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           axi_awvalid,
  input  logic                           axi_awready,
  output logic [ADDR_WIDTH-1:0]          axi_awaddr,
  output logic [7:0]                     axi_awlen,
  output logic [2:0]                     axi_awsize,
  output logic [1:0]                     axi_awburst,
  output logic                           axi_wvalid,
  input  logic                           axi_wready,
  output logic [DATA_WIDTH-1:0]          axi_wdata,
  output logic [DATA_WIDTH/8-1:0]        axi_wstrb,
  output logic                           axi_wlast,
  input  logic                           axi_bvalid,
  output logic                           axi_bready,
  input  logic [1:0]                     axi_bresp
);

  localparam int LANES       = DATA_WIDTH / WORD_BITS;
  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int TOTAL_WORDS = ROWS * COLS * ACC_WIDTH / WORD_BITS;
  localparam int BEATS_FULL  = TOTAL_WORDS / LANES;
  localparam int BEATS_PACK  = BEATS_FULL / 2;
  localparam int BEAT_W      = $clog2(BEATS_FULL + 1);
  localparam int IDX_W       = $clog2(TOTAL_WORDS + LANES);
  localparam int LEN_W       = $clog2(MAX_BURST + 1);

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  pack16_q, pack16_d;
  logic [BEAT_W-1:0]     sent_q, sent_d;
  logic [IDX_W-1:0]      word_idx_q, word_idx_d;
  logic [LEN_W-1:0]      burst_len_q, burst_len_d;
  logic [LEN_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [BEAT_W-1:0]     total_beats;
  logic [31:0]           rem_beats;
  logic [31:0]           beats_to_bound;
  logic [31:0]           next_len;
  logic                  last_beat;
  logic [DATA_WIDTH-1:0] beat_data;

  tensor_word_sel #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .ACC_WIDTH (ACC_WIDTH),
    .LANES     (LANES),
    .IDX_W     (IDX_W)
  ) u_word_sel (
    .regfiles_i (regfiles),
    .word_idx_i (word_idx_q),
    .pack16_i   (pack16_q),
    .beat_o     (beat_data)
  );

  // Next burst length: capped by MAX_BURST, the beats left, and the distance to the 4KB page end.
  always_comb begin
    total_beats    = pack16_q ? BEAT_W'(BEATS_PACK) : BEAT_W'(BEATS_FULL);
    cur_addr       = base_q + ADDR_WIDTH'(sent_q) * ADDR_WIDTH'(BYTES);
    rem_beats      = 32'(total_beats - sent_q);
    beats_to_bound = (32'(BOUNDARY_BYTES) - 32'(cur_addr[BOUNDARY_LSB-1:0])) / 32'(BYTES);
    next_len       = 32'(MAX_BURST);
    if (rem_beats < next_len)      next_len = rem_beats;
    if (beats_to_bound < next_len) next_len = beats_to_bound;
    last_beat      = (burst_cnt_q == burst_len_q - LEN_W'(1));
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    pack16_d    = pack16_q;
    sent_d      = sent_q;
    word_idx_d  = word_idx_q;
    burst_len_d = burst_len_q;
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          state_d    = ST_ADDR;
          base_d     = base_addr;
          pack16_d   = pack16;
          sent_d     = '0;
          word_idx_d = '0;
          err_d      = 1'b0;
        end
      end
      ST_ADDR: begin
        if (axi_awready) begin
          state_d     = ST_DATA;
          burst_len_d = LEN_W'(next_len);
          burst_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (axi_wready) begin
          sent_d      = sent_q + BEAT_W'(1);
          word_idx_d  = word_idx_q + IDX_W'(LANES);
          burst_cnt_d = burst_cnt_q + LEN_W'(1);
          if (last_beat) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (axi_bvalid) begin
          err_d = err_q | (axi_bresp != AXI_RESP_OKAY);
          if (sent_q == total_beats) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      pack16_q    <= 1'b0;
      sent_q      <= '0;
      word_idx_q  <= '0;
      burst_len_q <= '0;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      pack16_q    <= pack16_d;
      sent_q      <= sent_d;
      word_idx_q  <= word_idx_d;
      burst_len_q <= burst_len_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign axi_awvalid = (state_q == ST_ADDR);
  assign axi_awaddr  = axi_awvalid ? cur_addr : '0;
  assign axi_awlen   = axi_awvalid ? 8'(next_len - 32'd1) : 8'd0;
  assign axi_awsize  = clog2_bytes(DATA_WIDTH);
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_wvalid  = (state_q == ST_DATA);
  assign axi_wdata   = axi_wvalid ? beat_data : '0;
  assign axi_wstrb   = '1;
  assign axi_wlast   = axi_wvalid && last_beat;
  assign axi_bready  = (state_q == ST_RESP);

endmodule

// File: tb/tb_axi_tensor_wb.sv
// tb/tb_axi_tensor_wb.sv - scoreboard bench for axi_tensor_wb with an AXI write-slave model
module tb_axi_tensor_wb;

  localparam int AW = 32, DW = 64, ROWS = 8, COLS = 8, ACC = 128, MAXB = 16;
  localparam int NPE = ROWS * COLS;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pack16 = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [ROWS*COLS*ACC-1:0] regfiles;
  logic busy, done, err, awvalid, wvalid, wlast, bready;
  logic [AW-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0] bresp = 2'b00;

  always #5 clk = ~clk;

  axi_tensor_wb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS),
                  .ACC_WIDTH(ACC), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .pack16(pack16),
    .regfiles(regfiles), .busy(busy), .done(done), .err(err),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awlen(awlen),
    .axi_awsize(awsize), .axi_awburst(awburst), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp)
  );

  typedef struct packed { logic [63:0] data; logic last; } beat_t;
  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;

  beat_t exp_beats[$];
  aw_t   exp_aw[$];
  aw_t   aw_log[$];
  logic [63:0] beat_log[$];
  logic [ACC-1:0] rf_m [ROWS][COLS];

  int vectors = 0, miscompares = 0;
  bit bp_mode = 1'b0;
  int err_burst = -1;
  int done_cnt = 0, w_cnt = 0, b_cnt = 0, busy_cycles = 0;
  int done_base = 0, w_base = 0, b_base = 0, aw_base = 0, busy_base = 0;
  logic err_at_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i, input bit pk);
    int wave, pe;
    logic [ACC-1:0] e;
    wave = i / NPE;
    pe   = i % NPE;
    e    = rf_m[pe / COLS][pe % COLS];
    if (pk) return {e[(2*wave+1)*32 +: 16], e[2*wave*32 +: 16]};
    return e[wave*32 +: 32];
  endfunction

  task automatic plan_job(input logic [31:0] base, input bit pk);
    int total, sent, len, room;
    logic [31:0] addr;
    beat_t bt;
    aw_t a;
    total = pk ? 64 : 128;
    sent  = 0;
    while (sent < total) begin
      addr = base + 32'(sent * 8);
      room = (4096 - int'(addr[11:0])) / 8;
      len  = MAXB;
      if (total - sent < len) len = total - sent;
      if (room < len) len = room;
      a.addr = addr;
      a.len  = 8'(len - 1);
      exp_aw.push_back(a);
      for (int b = 0; b < len; b++) begin
        bt.data = {exp_word(2*(sent+b)+1, pk), exp_word(2*(sent+b), pk)};
        bt.last = (b == len - 1);
        exp_beats.push_back(bt);
      end
      sent += len;
    end
  endtask

  task automatic start_job(input logic [31:0] base, input bit pk);
    plan_job(base, pk);
    done_base = done_cnt; w_base = w_cnt; b_base = b_cnt;
    aw_base = aw_log.size(); busy_base = busy_cycles;
    @(negedge clk);
    base_addr = base; pack16 = pk; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = '0; pack16 = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("awvalid_after_start", awvalid, 1);
    chk("err_cleared_by_start", err, 0);
  endtask

  task automatic finish_job(input bit exp_err, input int exp_busy, input int nbeats,
                            input int nbursts, input bit poke_start);
    int guard;
    guard = 0;
    while (!done && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("done_timeout", guard < 3000, 1);
    if (poke_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_at_done_ignored", busy, 0);
    end
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt - done_base), 1);
    chk("err_at_done", err_at_done, exp_err);
    chk("err_sticky", err, exp_err);
    chk("beat_count", 64'(w_cnt - w_base), 64'(nbeats));
    chk("burst_count", 64'(aw_log.size() - aw_base), 64'(nbursts));
    chk("scoreboard_empty", 64'(exp_beats.size() + exp_aw.size()), 0);
    if (exp_busy > 0) chk("busy_cycles", 64'(busy_cycles - busy_base), 64'(exp_busy));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_awaddr"}, awaddr, 0);
    chk({tag, "_awlen"}, awlen, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wlast"}, wlast, 0);
    chk({tag, "_awsize"}, awsize, 3);
    chk({tag, "_awburst"}, awburst, 1);
    chk({tag, "_wstrb"}, wstrb, 8'hFF);
  endtask

  // Slave model and monitor: drives readies at each negedge and scores the handshakes that follow.
  initial begin
    bit pending_b, prev_wstall, prev_awstall, prev_wlast;
    logic [63:0] prev_wdata;
    logic [31:0] prev_awaddr;
    aw_t a;
    beat_t e;
    pending_b = 0; prev_wstall = 0; prev_awstall = 0; prev_wlast = 0;
    prev_wdata = '0; prev_awaddr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_beats.delete();
        exp_aw.delete();
        pending_b = 0; prev_wstall = 0; prev_awstall = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      end else begin
        awready = bp_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        wready  = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        bvalid  = pending_b && (bp_mode ? ($urandom_range(0, 1) == 0) : 1'b1);
        bresp   = (bvalid && (b_cnt - b_base == err_burst)) ? 2'b10 : 2'b00;
        if (busy) busy_cycles++;
        if (done) begin
          done_cnt++;
          err_at_done = err;
        end
        if (prev_awstall) begin
          chk("aw_hold_valid", awvalid, 1);
          chk("aw_hold_addr", awaddr, prev_awaddr);
        end
        if (prev_wstall) begin
          chk("w_hold_valid", wvalid, 1);
          chk("w_hold_data", wdata, prev_wdata);
          chk("w_hold_last", wlast, prev_wlast);
        end
        if (awvalid && awready) begin
          aw_log.push_back(aw_t'({awaddr, awlen}));
          if (exp_aw.size() == 0) chk("aw_extra", 1, 0);
          else begin
            a = exp_aw.pop_front();
            chk("awaddr", awaddr, a.addr);
            chk("awlen", awlen, a.len);
          end
        end
        if (wvalid && wready) begin
          w_cnt++;
          beat_log.push_back(wdata);
          if (exp_beats.size() == 0) chk("beat_extra", 1, 0);
          else begin
            e = exp_beats.pop_front();
            chk("wdata", wdata, e.data);
            chk("wlast", wlast, e.last);
          end
          if (wlast) pending_b = 1;
        end
        if (bvalid && bready) begin
          b_cnt++;
          pending_b = 0;
        end
        prev_awstall = awvalid && !awready;
        prev_awaddr  = awaddr;
        prev_wstall  = wvalid && !wready;
        prev_wdata   = wdata;
        prev_wlast   = wlast;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        rf_m[r][c] = {$urandom, $urandom, $urandom, $urandom};
        regfiles[(r*COLS+c)*ACC +: ACC] = rf_m[r][c];
      end

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    #3 rst = 1'b0;

    // Normal mode, zero-wait slave
    start_job(32'h0, 1'b0);
    finish_job(1'b0, 144, 128, 8, 1'b0);
    chk("first_beat", beat_log[w_base], {rf_m[0][1][31:0], rf_m[0][0][31:0]});
    chk("aw1_addr", aw_log[aw_base+1].addr, 32'h80);
    chk("aw7_addr", aw_log[aw_base+7].addr, 32'h380);
    chk("aw7_len", aw_log[aw_base+7].len, 15);

    // pack16
    start_job(32'h0, 1'b1);
    finish_job(1'b0, 72, 64, 4, 1'b0);
    chk("pack_word0", beat_log[w_base][31:0], {rf_m[0][0][47:32], rf_m[0][0][15:0]});
    chk("pack_word64", beat_log[w_base+32][31:0], {rf_m[0][0][111:96], rf_m[0][0][79:64]});

    // 4KB boundary split
    start_job(32'hFC0, 1'b0);
    finish_job(1'b0, 146, 128, 9, 1'b0);
    chk("split0_addr", aw_log[aw_base].addr, 32'hFC0);
    chk("split0_len", aw_log[aw_base].len, 7);
    chk("split1_addr", aw_log[aw_base+1].addr, 32'h1000);
    chk("split1_len", aw_log[aw_base+1].len, 15);
    chk("split_last_len", aw_log[aw_base+8].len, 7);

    // Random backpressure plus an ignored start while busy
    bp_mode = 1'b1;
    start_job(32'h2000, 1'b0);
    repeat (20) @(negedge clk);
    base_addr = 32'h5000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = '0;
    finish_job(1'b0, 0, 128, 8, 1'b0);
    bp_mode = 1'b0;

    // SLVERR on burst 3, start at done ignored, then err cleared by new start
    err_burst = 3;
    start_job(32'h0, 1'b0);
    finish_job(1'b1, 144, 128, 8, 1'b1);
    err_burst = -1;
    start_job(32'h0, 1'b0);
    finish_job(1'b0, 144, 128, 8, 1'b0);

    // Reset mid-DATA, with err already set by a failing first burst
    err_burst = 0;
    start_job(32'h0, 1'b0);
    guard = 0;
    while (w_cnt - w_base < 40 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    chk("beat40_timeout", guard < 2000, 1);
    chk("err_before_reset", err, 1);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    err_burst = -1;
    start_job(32'h0, 1'b0);
    finish_job(1'b0, 144, 128, 8, 1'b0);
    chk("post_reset_first_beat", beat_log[w_base], {rf_m[0][1][31:0], rf_m[0][0][31:0]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
